zeroriscy_dmem_arbiter: RTL and testbench
=========================================

# zeroriscy_dmem_arbiter

Shares the single simulation data memory between the zero-riscy LSU and a host/loader port, using the core's req/gnt/rvalid protocol on both sides. Decodes the tohost and console addresses and raises pulse outputs for the verilator top to consume. Sits in `zeroriscy_sim_top`, between `zeroriscy_core` data port, the host port and the data RAM.

## Interface

Parameters:
- `MEM_BASE`, 32'h8000_0000, byte base of data RAM
- `MEM_WORDS`, 393216, RAM depth in 32-bit words; RAM spans `MEM_BASE` .. `MEM_BASE+4*MEM_WORDS-1`
- `CONSOLE_ADDR`, 32'h9a10_0000, console byte sink
- `TOHOST0/1/2`, 32'h8000_1000 / 32'h8000_3000 / 32'h8017_fffc, tohost words

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `data_req_i` in 1 / `data_we_i` in 1 / `data_be_i` in 4 / `data_addr_i` in 32 / `data_wdata_i` in 32: core request
- `data_gnt_o` out 1 / `data_rvalid_o` out 1 / `data_rdata_o` out 32 / `data_err_o` out 1: core response
- `host_req_i` in 1 / `host_we_i` in 1 / `host_addr_i` in 32 / `host_wdata_i` in 32: host request, always full-word
- `host_gnt_o` out 1 / `host_rvalid_o` out 1 / `host_rdata_o` out 32 / `host_err_o` out 1: host response
- `mem_req_o` out 1 / `mem_we_o` out 1 / `mem_be_o` out 4 / `mem_addr_o` out 30 (word index) / `mem_wdata_o` out 32: RAM port
- `mem_rdata_i` in 32: RAM read data, valid exactly one cycle after `mem_req_o`
- `tohost_valid_o` out 1 / `tohost_data_o` out 32: core tohost write capture
- `console_valid_o` out 1 / `console_char_o` out 8: console byte

## Operation

- Grant is combinational in the request cycle; at most one of `data_gnt_o`/`host_gnt_o` high per cycle. Back-to-back grants every cycle permitted (RAM is fully pipelined).
- Arbitration: both requesting -> winner per Configuration; one requesting -> it wins.
- Granted request decode (priority order): console (core write to `CONSOLE_ADDR`) -> no RAM access, `console_valid_o` pulse next cycle with `wdata[7:0]`; in RAM window -> `mem_req_o`=1, `mem_addr_o`=(addr-`MEM_BASE`)>>2, be/we/wdata passed (host be=4'hF); otherwise -> error, no RAM access.
- Core write to any TOHOSTn: also forwarded to RAM; `tohost_valid_o` pulses next cycle with `tohost_data_o`=wdata. Host writes to those addresses do not pulse.
- Response register `rsp_owner_q` ∈ {NONE, CORE, HOST} plus `rsp_kind_q` ∈ {MEM, CONSOLE, ERR}, loaded on each grant, NONE otherwise.
- Next cycle: owner's `rvalid`=1; rdata = `mem_rdata_i` (MEM), 0 (CONSOLE, ERR); `err`=1 only for ERR. Non-owner rvalid/err = 0; rdata outputs are 0 whenever their rvalid is 0.
- Reads and writes both return rvalid.

## Timing

- Request->grant: 0 cycles. Grant->rvalid: exactly 1 cycle. tohost/console pulses: 1 cycle after grant, width 1 cycle.
- Reset: all outputs 0, `rsp_owner_q`=NONE, round-robin pointer = CORE-last (host wins first tie). Reset asserted during an in-flight access drops its rvalid; no grants while `reset`=1.
- Simultaneous response of access N and grant of N+1 in same cycle is normal operation.
- Unaligned addresses: low two bits ignored for decode and indexing.
- Address exactly `MEM_BASE+4*MEM_WORDS` -> ERR; `MEM_BASE+4*MEM_WORDS-4` -> MEM.

## Configuration

- `DMEM_ARB_ROUND_ROBIN_EN` defined: on contention, winner alternates; pointer updates only on contended grants to favour the loser.
- Undefined: fixed priority, core always wins contention; host may starve. Non-contended behaviour identical.

## Test plan

- Core read 0x8000_0010 alone -> gnt same cycle, `mem_addr_o`=4, rvalid next cycle with RAM data, host_rvalid 0.
- Core write 1 to 0x8000_1000 -> RAM write plus `tohost_valid_o`=1, `tohost_data_o`=1 next cycle; host write to same address -> no pulse.
- Core write 0x41 to 0x9a10_0000 -> `mem_req_o`=0, `console_valid_o`=1 with char 0x41, data_rvalid 1, err 0.
- Host read 0x0000_0000 -> host_gnt, no RAM access, host_rvalid + host_err next cycle, rdata 0.
- Both request for 4 cycles -> with macro grants H,C,H,C; without, C,C,C,C; all rvalids one cycle after their grant.
- Reset asserted the cycle after a core grant -> no data_rvalid, all outputs 0 during and the cycle after reset.

Source files
------------

// File: rtl/zeroriscy_dmem_arbiter.sv
// Shares the simulation data RAM between the zero-riscy LSU and a host/loader port,
// and decodes tohost/console writes. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention.
module zeroriscy_dmem_arbiter #(
    parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
    parameter int unsigned MEM_WORDS    = 393216,
    parameter logic [31:0] CONSOLE_ADDR = 32'h9a10_0000,
    parameter logic [31:0] TOHOST0      = 32'h8000_1000,
    parameter logic [31:0] TOHOST1      = 32'h8000_3000,
    parameter logic [31:0] TOHOST2      = 32'h8017_fffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_gnt_o,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic        host_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        console_valid_o,
    output logic [7:0]  console_char_o
);
    typedef enum logic [1:0] {OWNER_NONE, OWNER_CORE, OWNER_HOST} owner_e;
    typedef enum logic [1:0] {KIND_MEM, KIND_CONSOLE, KIND_ERR} kind_e;

    localparam logic [29:0] BASE_WORD  = MEM_BASE[31:2];
    localparam logic [29:0] WORD_COUNT = 30'(MEM_WORDS);

    logic        contended, core_pref;
    logic        core_gnt, host_gnt, any_gnt;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [29:0] sel_word, ram_word;
    logic [31:0] sel_wdata;
    logic        is_console, in_ram, mem_access, is_tohost;

    owner_e      rsp_owner_q, rsp_owner_d;
    kind_e       rsp_kind_q, rsp_kind_d;
    logic        tohost_valid_q;
    logic [31:0] tohost_data_q;
    logic        console_valid_q;
    logic [7:0]  console_char_q;

    // Byte offsets within a word play no part in decode or indexing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_addr_i[1:0], host_addr_i[1:0]};

    assign contended = data_req_i && host_req_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Set when the core won the last contended grant, so the host wins the next tie.
    logic rr_core_last_q;
    always_ff @(posedge clk) begin
        if (reset)          rr_core_last_q <= 1'b1;
        else if (contended) rr_core_last_q <= core_gnt;
    end
    assign core_pref = !rr_core_last_q;
`else
    assign core_pref = 1'b1;
`endif

    always_comb begin
        // NOTE: grants are combinational but masked by reset so nothing is accepted while it is held.
        core_gnt   = !reset && data_req_i && (!contended || core_pref);
        host_gnt   = !reset && host_req_i && !(contended && core_pref);
        any_gnt    = core_gnt || host_gnt;

        sel_we     = core_gnt ? data_we_i         : host_we_i;
        sel_be     = core_gnt ? data_be_i         : 4'hF;
        sel_word   = core_gnt ? data_addr_i[31:2] : host_addr_i[31:2];
        sel_wdata  = core_gnt ? data_wdata_i      : host_wdata_i;

        ram_word   = sel_word - BASE_WORD;
        in_ram     = (sel_word >= BASE_WORD) && (ram_word < WORD_COUNT);
        is_console = core_gnt && data_we_i && (data_addr_i[31:2] == CONSOLE_ADDR[31:2]);
        mem_access = any_gnt && in_ram && !is_console;
        is_tohost  = core_gnt && data_we_i && mem_access &&
                     ((sel_word == TOHOST0[31:2]) || (sel_word == TOHOST1[31:2]) ||
                      (sel_word == TOHOST2[31:2]));

        rsp_owner_d = OWNER_NONE;
        if (core_gnt)      rsp_owner_d = OWNER_CORE;
        else if (host_gnt) rsp_owner_d = OWNER_HOST;

        rsp_kind_d = KIND_ERR;
        if (is_console)      rsp_kind_d = KIND_CONSOLE;
        else if (mem_access) rsp_kind_d = KIND_MEM;
    end

    assign data_gnt_o  = core_gnt;
    assign host_gnt_o  = host_gnt;
    assign mem_req_o   = mem_access;
    assign mem_we_o    = mem_access && sel_we;
    assign mem_be_o    = mem_access ? sel_be    : 4'h0;
    assign mem_addr_o  = mem_access ? ram_word  : 30'd0;
    assign mem_wdata_o = mem_access ? sel_wdata : 32'd0;

    // NOTE: all state here is sequential and assigned non-blocking; the RAM itself lives outside.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_owner_q     <= OWNER_NONE;
            rsp_kind_q      <= KIND_MEM;
            tohost_valid_q  <= 1'b0;
            tohost_data_q   <= 32'd0;
            console_valid_q <= 1'b0;
            console_char_q  <= 8'd0;
        end else begin
            rsp_owner_q     <= rsp_owner_d;
            rsp_kind_q      <= rsp_kind_d;
            tohost_valid_q  <= is_tohost;
            tohost_data_q   <= is_tohost ? data_wdata_i : 32'd0;
            console_valid_q <= is_console;
            console_char_q  <= is_console ? data_wdata_i[7:0] : 8'd0;
        end
    end

    // Responses are masked by reset so an access in flight when reset rises returns nothing.
    assign data_rvalid_o   = !reset && (rsp_owner_q == OWNER_CORE);
    assign host_rvalid_o   = !reset && (rsp_owner_q == OWNER_HOST);
    assign data_err_o      = data_rvalid_o && (rsp_kind_q == KIND_ERR);
    assign host_err_o      = host_rvalid_o && (rsp_kind_q == KIND_ERR);
    assign data_rdata_o    = (data_rvalid_o && rsp_kind_q == KIND_MEM) ? mem_rdata_i : 32'd0;
    assign host_rdata_o    = (host_rvalid_o && rsp_kind_q == KIND_MEM) ? mem_rdata_i : 32'd0;
    assign tohost_valid_o  = !reset && tohost_valid_q;
    assign tohost_data_o   = tohost_valid_o ? tohost_data_q : 32'd0;
    assign console_valid_o = !reset && console_valid_q;
    assign console_char_o  = console_valid_o ? console_char_q : 8'd0;
endmodule

// File: tb/tb_zeroriscy_dmem_arbiter.sv
// Self-checking bench for zeroriscy_dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honours DMEM_ARB_ROUND_ROBIN_EN.
module tb_zeroriscy_dmem_arbiter;
    localparam logic [31:0] MEM_BASE     = 32'h8000_0000;
    localparam int unsigned MEM_WORDS    = 393216;
    localparam logic [31:0] CONSOLE_ADDR = 32'h9a10_0000;
    localparam logic [31:0] TOHOST0      = 32'h8000_1000;
    localparam logic [31:0] TOHOST1      = 32'h8000_3000;
    localparam logic [31:0] TOHOST2      = 32'h8017_fffc;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        host_req_i, host_we_i;
    logic [31:0] host_addr_i, host_wdata_i;
    logic        host_gnt_o, host_rvalid_o, host_err_o;
    logic [31:0] host_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        tohost_valid_o, console_valid_o;
    logic [31:0] tohost_data_o;
    logic [7:0]  console_char_o;

    int n_tests = 0;
    int n_fail  = 0;

    zeroriscy_dmem_arbiter #(
        .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS), .CONSOLE_ADDR(CONSOLE_ADDR),
        .TOHOST0(TOHOST0), .TOHOST1(TOHOST1), .TOHOST2(TOHOST2)
    ) dut (
        .clk(clk), .reset(reset),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .tohost_valid_o(tohost_valid_o), .tohost_data_o(tohost_data_o),
        .console_valid_o(console_valid_o), .console_char_o(console_char_o)
    );

    always #5 clk = ~clk;

    logic [179:0] all_outs;
    assign all_outs = {data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
                       host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
                       mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                       tohost_valid_o, tohost_data_o, console_valid_o, console_char_o};

    // Reference model: owner 0=none 1=core 2=host; kind 0=mem 1=console 2=error.
    int          m_owner = 0, m_kind = 0;
    bit          m_thv = 0, m_cv = 0, m_host_tie = 1;
    logic [31:0] m_thd = 0;
    logic [7:0]  m_cc = 0;
    int          nx_owner, nx_kind;
    bit          nx_thv, nx_cv;
    logic [31:0] nx_thd;
    logic [7:0]  nx_cc;
    logic        e_dgnt, e_hgnt, e_mreq, e_mwe, e_drv, e_derr, e_hrv, e_herr, e_thv, e_cv;
    logic [3:0]  e_mbe;
    logic [29:0] e_maddr;
    logic [31:0] e_mwdata, e_drd, e_hrd, e_thd;
    logic [7:0]  e_cc;

    task automatic model_eval();
        bit              host_tie_wins, we, console, ram;
        logic [31:0]     a, wd;
        logic [3:0]      be;
        longint unsigned aligned, lo, hi;
        {e_dgnt, e_hgnt, e_mreq, e_mwe, e_drv, e_derr, e_hrv, e_herr, e_thv, e_cv} = '0;
        e_mbe = '0; e_maddr = '0; e_mwdata = '0; e_drd = '0; e_hrd = '0; e_thd = '0; e_cc = '0;
        nx_owner = 0; nx_kind = 0; nx_thv = 0; nx_cv = 0; nx_thd = '0; nx_cc = '0;
        if (reset) return;
        e_drv  = (m_owner == 1);
        e_hrv  = (m_owner == 2);
        e_derr = e_drv && (m_kind == 2);
        e_herr = e_hrv && (m_kind == 2);
        e_drd  = (e_drv && m_kind == 0) ? mem_rdata_i : 32'd0;
        e_hrd  = (e_hrv && m_kind == 0) ? mem_rdata_i : 32'd0;
        e_thv  = m_thv;
        e_thd  = m_thv ? m_thd : 32'd0;
        e_cv   = m_cv;
        e_cc   = m_cv ? m_cc : 8'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        host_tie_wins = m_host_tie;
`else
        host_tie_wins = 1'b0;
`endif
        e_dgnt = data_req_i && !(host_req_i && host_tie_wins);
        e_hgnt = host_req_i && !e_dgnt;
        if (!e_dgnt && !e_hgnt) return;
        a  = e_dgnt ? data_addr_i  : host_addr_i;
        wd = e_dgnt ? data_wdata_i : host_wdata_i;
        we = e_dgnt ? data_we_i    : host_we_i;
        be = e_dgnt ? data_be_i    : 4'hF;
        aligned = {32'd0, a[31:2], 2'b00};
        lo = {32'd0, MEM_BASE};
        hi = lo + 4 * longint'(MEM_WORDS);
        console = e_dgnt && we && (aligned == {32'd0, CONSOLE_ADDR});
        ram = !console && aligned >= lo && aligned < hi;
        nx_owner = e_dgnt ? 1 : 2;
        nx_kind  = console ? 1 : (ram ? 0 : 2);
        if (ram) begin
            e_mreq = 1; e_mwe = we; e_mbe = be; e_mwdata = wd;
            e_maddr = 30'((aligned - lo) >> 2);
        end
        nx_thv = e_dgnt && we && (aligned == {32'd0, TOHOST0} || aligned == {32'd0, TOHOST1} ||
                                  aligned == {32'd0, TOHOST2});
        nx_thd = wd;
        nx_cv  = console;
        nx_cc  = wd[7:0];
    endtask

    task automatic model_commit();
        model_eval();
        if (reset) begin
            m_owner = 0; m_kind = 0; m_thv = 0; m_cv = 0; m_host_tie = 1;
        end else begin
            m_owner = nx_owner; m_kind = nx_kind;
            m_thv = nx_thv; m_thd = nx_thd; m_cv = nx_cv; m_cc = nx_cc;
            if (data_req_i && host_req_i) m_host_tie = !m_host_tie;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        mem_rdata_i = $urandom();
    endtask

    task automatic idle();
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wdata_i = 0;
    endtask

    task automatic core_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_req_i = 1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
    endtask

    task automatic host_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        host_req_i = 1; host_we_i = we; host_addr_i = addr; host_wdata_i = wdata;
    endtask

    task automatic test_reset();
        reset = 1;
        core_req(1, 4'hF, MEM_BASE, 32'h1234_5678);
        host_req(0, MEM_BASE + 32'h40, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (all_outs !== '0) begin
                n_fail++; $display("FAIL reset_outputs: got %h, want 0", all_outs);
            end
            advance();
        end
        reset = 0; idle();
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_idle: got %h, want 0", all_outs);
        end
        advance();
    endtask

    task automatic test_core_read();
        logic [31:0] rd;
        core_req(0, 4'hF, 32'h8000_0010, 0);
        #1;
        n_tests++;
        if ({data_gnt_o, host_gnt_o, mem_req_o, mem_we_o, mem_addr_o} !== {4'b1010, 30'd4}) begin
            n_fail++; $display("FAIL core_read_issue: gnt=%b/%b req=%b we=%b addr=%0d, want 1/0 1 0 4",
                               data_gnt_o, host_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
        end
        advance(); idle(); rd = mem_rdata_i;
        #1;
        n_tests++;
        if ({data_rvalid_o, data_err_o, host_rvalid_o, data_rdata_o} !== {3'b100, rd}) begin
            n_fail++; $display("FAIL core_read_rsp: rvalid=%b err=%b host_rvalid=%b rdata=%h, want 1 0 0 %h",
                               data_rvalid_o, data_err_o, host_rvalid_o, data_rdata_o, rd);
        end
        advance();
    endtask

    task automatic test_tohost();
        core_req(1, 4'hF, TOHOST0, 32'd1);
        #1;
        n_tests++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 30'h400, 32'd1}) begin
            n_fail++; $display("FAIL tohost_ram_write: req=%b we=%b addr=%h wdata=%h, want 1 1 400 1",
                               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        advance(); idle();
        host_req(1, TOHOST0, 32'd7);
        #1;
        n_tests++;
        if ({tohost_valid_o, tohost_data_o, data_rvalid_o} !== {1'b1, 32'd1, 1'b1}) begin
            n_fail++; $display("FAIL tohost_pulse: valid=%b data=%h rvalid=%b, want 1 1 1",
                               tohost_valid_o, tohost_data_o, data_rvalid_o);
        end
        n_tests++;
        if ({host_gnt_o, mem_req_o, mem_we_o, mem_be_o} !== 7'b111_1111) begin
            n_fail++; $display("FAIL host_tohost_write: gnt=%b req=%b we=%b be=%h, want 1 1 1 f",
                               host_gnt_o, mem_req_o, mem_we_o, mem_be_o);
        end
        advance(); idle();
        #1;
        n_tests++;
        if ({tohost_valid_o, host_rvalid_o, host_err_o} !== 3'b010) begin
            n_fail++; $display("FAIL host_tohost_nopulse: tohost_valid=%b host_rvalid=%b err=%b, want 0 1 0",
                               tohost_valid_o, host_rvalid_o, host_err_o);
        end
        advance();
    endtask

    task automatic test_console();
        core_req(1, 4'h1, CONSOLE_ADDR, 32'h0000_0041);
        #1;
        n_tests++;
        if ({data_gnt_o, mem_req_o} !== 2'b10) begin
            n_fail++; $display("FAIL console_issue: gnt=%b mem_req=%b, want 1 0", data_gnt_o, mem_req_o);
        end
        advance(); idle();
        #1;
        n_tests++;
        if ({console_valid_o, console_char_o, data_rvalid_o, data_err_o, data_rdata_o} !==
            {1'b1, 8'h41, 2'b10, 32'd0}) begin
            n_fail++; $display("FAIL console_rsp: valid=%b char=%h rvalid=%b err=%b rdata=%h, want 1 41 1 0 0",
                               console_valid_o, console_char_o, data_rvalid_o, data_err_o, data_rdata_o);
        end
        advance();
    endtask

    task automatic test_host_err();
        host_req(0, 32'h0000_0000, 0);
        #1;
        n_tests++;
        if ({host_gnt_o, data_gnt_o, mem_req_o} !== 3'b100) begin
            n_fail++; $display("FAIL host_err_issue: host_gnt=%b data_gnt=%b mem_req=%b, want 1 0 0",
                               host_gnt_o, data_gnt_o, mem_req_o);
        end
        advance(); idle();
        #1;
        n_tests++;
        if ({host_rvalid_o, host_err_o, host_rdata_o, data_rvalid_o} !== {2'b11, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL host_err_rsp: rvalid=%b err=%b rdata=%h data_rvalid=%b, want 1 1 0 0",
                               host_rvalid_o, host_err_o, host_rdata_o, data_rvalid_o);
        end
        advance();
    endtask

    task automatic test_boundary();
        core_req(0, 4'hF, MEM_BASE + 32'(4 * MEM_WORDS), 0);
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL bound_past_end: mem_req=%b, want 0", mem_req_o);
        end
        advance();
        core_req(0, 4'hF, MEM_BASE + 32'(4 * MEM_WORDS) - 32'd4, 0);
        #1;
        n_tests++;
        if ({data_rvalid_o, data_err_o} !== 2'b11) begin
            n_fail++; $display("FAIL bound_past_end_err: rvalid=%b err=%b, want 1 1", data_rvalid_o, data_err_o);
        end
        n_tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 30'(MEM_WORDS - 1)}) begin
            n_fail++; $display("FAIL bound_last_word: req=%b addr=%h, want 1 %h",
                               mem_req_o, mem_addr_o, 30'(MEM_WORDS - 1));
        end
        advance();
        core_req(0, 4'hF, 32'h8000_0013, 0);
        #1;
        n_tests++;
        if ({mem_req_o, mem_addr_o, data_err_o} !== {1'b1, 30'd4, 1'b0}) begin
            n_fail++; $display("FAIL unaligned: req=%b addr=%0d prev_err=%b, want 1 4 0",
                               mem_req_o, mem_addr_o, data_err_o);
        end
        advance(); idle();
        advance();
    endtask

    task automatic test_contention();
        string got = "";
        string want;
        byte   prev = "-";
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        want = "HCHC";
`else
        want = "CCCC";
`endif
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                core_req(0, 4'hF, MEM_BASE + 32'(16 * i), 0);
                host_req(0, MEM_BASE + 32'h100 + 32'(16 * i), 0);
            end
            #1;
            if (i > 0) begin
                n_tests++;
                if ({data_rvalid_o, host_rvalid_o} !== {prev == "C", prev == "H"}) begin
                    n_fail++; $display("FAIL contention_rvalid cycle %0d: data/host rvalid=%b/%b after grant %s",
                                       i, data_rvalid_o, host_rvalid_o, string'(prev));
                end
            end
            if (i < 4) begin
                prev = data_gnt_o && !host_gnt_o ? "C" : (host_gnt_o && !data_gnt_o ? "H" : "x");
                got = {got, string'(prev)};
            end
            advance();
        end
        n_tests++;
        if (got != want) begin
            n_fail++; $display("FAIL contention_order: got %s, want %s", got, want);
        end
    endtask

    task automatic test_reset_inflight();
        core_req(0, 4'hF, MEM_BASE + 32'h40, 0);
        #1;
        n_tests++;
        if (data_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL inflight_gnt: got %b, want 1", data_gnt_o);
        end
        advance();
        reset = 1; idle();
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL inflight_reset_outputs: got %h, want 0", all_outs);
        end
        advance();
        reset = 0;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL after_reset_outputs: got %h, want 0", all_outs);
        end
        advance();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return CONSOLE_ADDR | 32'($urandom_range(0, 3));
            1:       return TOHOST0;
            2:       return TOHOST1;
            3:       return TOHOST2;
            4:       return MEM_BASE + 32'(4 * MEM_WORDS) - 32'd4 + 32'($urandom_range(0, 7));
            5:       return $urandom();
            6:       return MEM_BASE + 32'($urandom_range(0, 63));
            default: return MEM_BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1));
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            data_req_i = 1'($urandom_range(0, 1)); data_we_i = 1'($urandom_range(0, 1));
            data_be_i = 4'($urandom_range(0, 15)); data_addr_i = rand_addr(); data_wdata_i = $urandom();
            host_req_i = 1'($urandom_range(0, 1)); host_we_i = 1'($urandom_range(0, 1));
            host_addr_i = rand_addr(); host_wdata_i = $urandom();
            #1;
            model_eval();
            n_tests++;
            if ({data_gnt_o, host_gnt_o} !== {e_dgnt, e_hgnt}) begin
                n_fail++; $display("FAIL rand_gnt cycle %0d: got %b%b, want %b%b",
                                   i, data_gnt_o, host_gnt_o, e_dgnt, e_hgnt);
            end
            n_tests++;
            if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
                {e_mreq, e_mwe, e_mbe, e_maddr, e_mwdata}) begin
                n_fail++; $display("FAIL rand_ram cycle %0d: got req=%b we=%b be=%h addr=%h wd=%h, want %b %b %h %h %h",
                                   i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                                   e_mreq, e_mwe, e_mbe, e_maddr, e_mwdata);
            end
            n_tests++;
            if ({data_rvalid_o, data_err_o, data_rdata_o} !== {e_drv, e_derr, e_drd}) begin
                n_fail++; $display("FAIL rand_core_rsp cycle %0d: got %b %b %h, want %b %b %h",
                                   i, data_rvalid_o, data_err_o, data_rdata_o, e_drv, e_derr, e_drd);
            end
            n_tests++;
            if ({host_rvalid_o, host_err_o, host_rdata_o} !== {e_hrv, e_herr, e_hrd}) begin
                n_fail++; $display("FAIL rand_host_rsp cycle %0d: got %b %b %h, want %b %b %h",
                                   i, host_rvalid_o, host_err_o, host_rdata_o, e_hrv, e_herr, e_hrd);
            end
            n_tests++;
            if ({tohost_valid_o, tohost_data_o, console_valid_o, console_char_o} !==
                {e_thv, e_thd, e_cv, e_cc}) begin
                n_fail++; $display("FAIL rand_pulses cycle %0d: got th=%b/%h con=%b/%h, want %b/%h %b/%h",
                                   i, tohost_valid_o, tohost_data_o, console_valid_o, console_char_o,
                                   e_thv, e_thd, e_cv, e_cc);
            end
            advance();
        end
        reset = 0; idle();
        advance();
    endtask

    initial begin
        reset = 1;
        mem_rdata_i = 32'd0;
        idle();
        test_reset();
        test_core_read();
        test_tohost();
        test_console();
        test_host_err();
        test_boundary();
        test_contention();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
